// File: rtl/seg_pkg.sv
// Shared constants for the scrolling 7-segment controller: segment codes,
// the default message ROM and the hex-to-segment mapping.
package seg_pkg;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Element i holds character i.
  localparam logic [15:0][3:0] MSG_ROM = {
    4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
    4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
  };

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic seg_t hex_to_seg(input hex_t h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// Button inputs and display pin outputs of the scroll controller.
interface seg_scroll_ctrl_if;
  logic       btn_fwd;
  logic       btn_back;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output btn_fwd, btn_back, input an, seg, dp);
  modport slave  (input btn_fwd, btn_back, output an, seg, dp);
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit to active-low segment decoder.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  hex_t hex_i,
  output seg_t seg_o
);
  assign seg_o = hex_to_seg(hex_i);
endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolls a hex message across a 4-digit common-anode display; one step per
// button press, multiplexed digits with a blank cycle between digits.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 50000
) (
  input logic          clk,
  input logic          reset,
  seg_scroll_ctrl_if.slave bus
);
  localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int RW = $clog2(REFRESH_DIV);

  logic          fwd_prev_q, back_prev_q;
  logic          fwd_pls, back_pls;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    dsel_q, dsel_d;
  logic          tick;
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;
  hex_t          chr;
  seg_t          chr_seg;
  logic          idx_zero;

  always_comb begin
    fwd_pls  = bus.btn_fwd & ~fwd_prev_q;
    back_pls = bus.btn_back & ~back_prev_q;
    ptr_d    = ptr_q;
    if (fwd_pls && !back_pls)
      ptr_d = (ptr_q == PW'(MSG_LEN - 1)) ? '0 : ptr_q + 1'b1;
    else if (back_pls && !fwd_pls)
      ptr_d = (ptr_q == '0) ? PW'(MSG_LEN - 1) : ptr_q - 1'b1;
  end

  always_comb begin
    tick   = (rcnt_q == RW'(REFRESH_DIV - 1));
    rcnt_d = tick ? '0 : rcnt_q + 1'b1;
    dsel_d = tick ? dsel_q + 1'b1 : dsel_q;
  end

  // ptr < MSG_LEN and dsel < 4 <= MSG_LEN, so one conditional subtract is a full modulo.
  always_comb begin : char_sel
    int sum;
    sum = int'(ptr_q) + int'(dsel_q);
    if (sum >= MSG_LEN) sum = sum - MSG_LEN;
    chr      = MSG_ROM[4'(sum)];
    idx_zero = (sum == 0);
  end

  seg_hex_decoder u_dec (.hex_i(chr), .seg_o(chr_seg));

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!tick) begin
      an_d  = ~(4'b1000 >> dsel_q);
      seg_d = chr_seg;
      dp_d  = ~idx_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_prev_q  <= 1'b0;
      back_prev_q <= 1'b0;
      ptr_q       <= '0;
      rcnt_q      <= '0;
      dsel_q      <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      fwd_prev_q  <= bus.btn_fwd;
      back_prev_q <= bus.btn_back;
      ptr_q       <= ptr_d;
      rcnt_q      <= rcnt_d;
      dsel_q      <= dsel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule
